// File: rtl/com_bus_arbiter_n_pkg.sv
// Shared definitions for the coherence-bus arbiter.
// Provides default core count / index width, FSM state encoding and
// request-class encoding used by the arbiter top and its testbench.
package com_bus_arbiter_n_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_CORE_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GNT_PROC  = 2'd1,
    ST_GNT_SNOOP = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    CLS_PROC  = 1'b0,
    CLS_SNOOP = 1'b1
  } req_class_t;

endpackage

// File: rtl/com_bus_arbiter_n_rr_pick_n.sv
// Round-robin picker: finds the first set request at or after ptr, wrapping
// modulo N (N need not be a power of two).
// Ports: req (request vector), ptr (search start) -> found, idx (winner).
module rr_pick_n #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int         cand;
  logic [W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the closest requester to ptr
  // is the last write and therefore wins, without needing a loop break.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter_n.sv
// Coherence-bus arbiter: one grant at a time across NUM_CORES wrappers, two
// request classes (proc, snoop) each with its own round-robin pointer,
// class priority, hold watchdog, and invalidation-ack aggregation.
// Ports: Com_Bus_Req_* in / Com_Bus_Gnt_* out (registered, 1-cycle latency),
// Invalidate + Invalidation_done in -> All_Invalidation_done out,
// Bus_busy / Bus_owner status, Hold_timeout one-cycle watchdog pulse.
module com_bus_arbiter_n
  import com_bus_arbiter_n_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int CORE_IDX_W     = DEF_CORE_IDX_W,
  parameter bit SNOOP_PRIORITY = 1'b1,
  parameter int MAX_HOLD       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CORES-1:0]  Com_Bus_Req_proc,
  input  logic [NUM_CORES-1:0]  Com_Bus_Req_snoop,
  output logic [NUM_CORES-1:0]  Com_Bus_Gnt_proc,
  output logic [NUM_CORES-1:0]  Com_Bus_Gnt_snoop,
  input  logic                  Invalidate,
  input  logic [NUM_CORES-1:0]  Invalidation_done,
  output logic                  All_Invalidation_done,
  output logic                  Bus_busy,
  output logic [CORE_IDX_W-1:0] Bus_owner,
  output logic                  Hold_timeout
);

  // Counter only needs to reach MAX_HOLD-1, the cycle on which release fires.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CORE_IDX_W-1:0] LAST_IDX = CORE_IDX_W'(NUM_CORES - 1);

  arb_state_t            state, state_d;
  logic [CORE_IDX_W-1:0] ptr_proc, ptr_proc_d;
  logic [CORE_IDX_W-1:0] ptr_snoop, ptr_snoop_d;
  logic [HOLD_W-1:0]     hold_cnt, hold_d;
  logic [NUM_CORES-1:0]  gnt_proc_q, gnt_proc_d;
  logic [NUM_CORES-1:0]  gnt_snoop_q, gnt_snoop_d;
  logic                  busy_q, busy_d;
  logic [CORE_IDX_W-1:0] owner_q, owner_d;
  logic                  timeout_q, timeout_d;
  logic                  aid_q, aid_d;

  logic                  proc_found, snoop_found;
  logic [CORE_IDX_W-1:0] proc_idx, snoop_idx;
  req_class_t            win_cls;
  logic                  owner_req;
  logic                  others_done;

  rr_pick_n #(.N(NUM_CORES), .W(CORE_IDX_W)) u_pick_proc (
    .req   (Com_Bus_Req_proc),
    .ptr   (ptr_proc),
    .found (proc_found),
    .idx   (proc_idx)
  );

  rr_pick_n #(.N(NUM_CORES), .W(CORE_IDX_W)) u_pick_snoop (
    .req   (Com_Bus_Req_snoop),
    .ptr   (ptr_snoop),
    .found (snoop_found),
    .idx   (snoop_idx)
  );

  // The owner never acknowledges its own invalidation, so exclude it.
  always_comb begin
    others_done = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (CORE_IDX_W'(i) != owner_q && !Invalidation_done[i]) others_done = 1'b0;
    end
  end

  always_comb begin
    win_cls = (snoop_found && (SNOOP_PRIORITY || !proc_found)) ? CLS_SNOOP : CLS_PROC;
    owner_req = (state == ST_GNT_PROC) ? Com_Bus_Req_proc[owner_q]
                                       : Com_Bus_Req_snoop[owner_q];
  end

  always_comb begin
    state_d     = state;
    ptr_proc_d  = ptr_proc;
    ptr_snoop_d = ptr_snoop;
    hold_d      = hold_cnt;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    busy_d      = busy_q;
    owner_d     = owner_q;
    timeout_d   = 1'b0;
    aid_d       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (proc_found || snoop_found) begin
          busy_d = 1'b1;
          hold_d = '0;
          if (win_cls == CLS_SNOOP) begin
            state_d     = ST_GNT_SNOOP;
            owner_d     = snoop_idx;
            gnt_snoop_d = NUM_CORES'(1) << snoop_idx;
            ptr_snoop_d = (snoop_idx == LAST_IDX) ? '0 : snoop_idx + 1'b1;
          end else begin
            state_d    = ST_GNT_PROC;
            owner_d    = proc_idx;
            gnt_proc_d = NUM_CORES'(1) << proc_idx;
            ptr_proc_d = (proc_idx == LAST_IDX) ? '0 : proc_idx + 1'b1;
          end
        end
      end

      ST_GNT_PROC, ST_GNT_SNOOP: begin
        if (!owner_req || (MAX_HOLD > 0 && hold_cnt == HOLD_LAST)) begin
          state_d     = ST_RELEASE;
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          busy_d      = 1'b0;
          // A voluntary drop on the last allowed cycle is not a timeout.
          timeout_d   = owner_req;
        end else begin
          // Below HOLD_LAST here, so the increment can never wrap.
          if (MAX_HOLD > 0) hold_d = hold_cnt + 1'b1;
          // Only produced while the proc grant persists, so the registered
          // flag is never seen outside GNT_PROC.
          aid_d = (state == ST_GNT_PROC) && Invalidate && others_done;
        end
      end

      ST_RELEASE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr_proc    <= '0;
      ptr_snoop   <= '0;
      hold_cnt    <= '0;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      busy_q      <= 1'b0;
      owner_q     <= '0;
      timeout_q   <= 1'b0;
      aid_q       <= 1'b0;
    end else begin
      state       <= state_d;
      ptr_proc    <= ptr_proc_d;
      ptr_snoop   <= ptr_snoop_d;
      hold_cnt    <= hold_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
      aid_q       <= aid_d;
    end
  end

  assign Com_Bus_Gnt_proc      = gnt_proc_q;
  assign Com_Bus_Gnt_snoop     = gnt_snoop_q;
  assign Bus_busy              = busy_q;
  assign Bus_owner             = owner_q;
  assign Hold_timeout          = timeout_q;
  assign All_Invalidation_done = aid_q;

endmodule

// File: tb/tb_com_bus_arbiter_n.sv
// Testbench for com_bus_arbiter_n: two instances sharing stimulus
// (snoop-first with MAX_HOLD=4, proc-first with watchdog disabled),
// each tracked by its own behavioural model, plus directed tables/sequences.
module tb_com_bus_arbiter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_p, req_s, inv_done;
  logic       inv;

  logic [3:0] a_gp, a_gs, b_gp, b_gs;
  logic       a_busy, a_to, a_aid, b_busy, b_to, b_aid;
  logic [1:0] a_own, b_own;

  always #5 clk = ~clk;

  com_bus_arbiter_n #(.NUM_CORES(4), .CORE_IDX_W(2), .SNOOP_PRIORITY(1'b1), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s),
    .Com_Bus_Gnt_proc(a_gp), .Com_Bus_Gnt_snoop(a_gs),
    .Invalidate(inv), .Invalidation_done(inv_done),
    .All_Invalidation_done(a_aid), .Bus_busy(a_busy),
    .Bus_owner(a_own), .Hold_timeout(a_to)
  );

  com_bus_arbiter_n #(.NUM_CORES(4), .CORE_IDX_W(2), .SNOOP_PRIORITY(1'b0), .MAX_HOLD(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc(req_p), .Com_Bus_Req_snoop(req_s),
    .Com_Bus_Gnt_proc(b_gp), .Com_Bus_Gnt_snoop(b_gs),
    .Invalidate(inv), .Invalidation_done(inv_done),
    .All_Invalidation_done(b_aid), .Bus_busy(b_busy),
    .Bus_owner(b_own), .Hold_timeout(b_to)
  );

  // Model view of the bus: who holds it, for how many cycles so far, and
  // whether we are in the dead cycle after a release.
  typedef struct {
    bit busy;
    bit dead;
    bit cls;     // 1 = snoop
    int owner;
    int held;    // granted cycles including the current one
    int ptr_p;
    int ptr_s;
    bit to;
    bit aid;
  } mdl_t;

  typedef struct {
    logic [3:0]  rp, rs, done;
    logic        inv;
    logic [12:0] exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  mdl_t ma, mb;
  vec_t tbl[19];
  int   order[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mdl_t mzero();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, bit sp, int mh, logic [3:0] rp, logic [3:0] rs,
                                logic iv, logic [3:0] dn);
    mdl_t       n;
    bit         r, all, use_s, use_p;
    logic [3:0] vec;
    int         p, c;
    n = m; n.to = 0; n.aid = 0;
    if (m.dead) begin
      n.dead = 0;
    end else if (m.busy) begin
      r = m.cls ? rs[m.owner] : rp[m.owner];
      if (!r) begin
        n.busy = 0; n.dead = 1;
      end else if (mh > 0 && m.held >= mh) begin
        n.busy = 0; n.dead = 1; n.to = 1;
      end else begin
        n.held = m.held + 1;
        all = 1;
        for (int i = 0; i < 4; i++) if (i != m.owner && !dn[i]) all = 0;
        n.aid = !m.cls && iv && all;
      end
    end else begin
      use_s = (rs != 0) && (sp || rp == 0);
      use_p = (rp != 0) && !use_s;
      if (use_s || use_p) begin
        vec = use_s ? rs : rp;
        p   = use_s ? m.ptr_s : m.ptr_p;
        c   = -1;
        for (int k = 0; k < 4; k++) if (c < 0 && vec[(p + k) % 4]) c = (p + k) % 4;
        n.busy = 1; n.cls = use_s; n.owner = c; n.held = 1;
        if (use_s) n.ptr_s = (c + 1) % 4; else n.ptr_p = (c + 1) % 4;
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] vis(mdl_t m);
    logic [3:0] gp, gs;
    gp = (m.busy && !m.cls) ? (4'b0001 << m.owner) : 4'b0000;
    gs = (m.busy &&  m.cls) ? (4'b0001 << m.owner) : 4'b0000;
    return {gp, gs, m.busy, (m.busy ? 2'(m.owner) : 2'b00), m.to, m.aid};
  endfunction

  function automatic logic [12:0] act_a();
    return {a_gp, a_gs, a_busy, (a_busy ? a_own : 2'b00), a_to, a_aid};
  endfunction

  function automatic logic [12:0] act_b();
    return {b_gp, b_gs, b_busy, (b_busy ? b_own : 2'b00), b_to, b_aid};
  endfunction

  function automatic vec_t mk(logic [3:0] rp, logic [3:0] rs, logic iv, logic [3:0] dn,
                              logic [3:0] gp, logic [3:0] gs, logic bz, logic [1:0] ow,
                              logic to, logic aid);
    vec_t v;
    v.rp = rp; v.rs = rs; v.inv = iv; v.done = dn;
    v.exp = {gp, gs, bz, ow, to, aid};
    return v;
  endfunction

  task automatic tick(input string name);
    ma = step(ma, 1'b1, 4, req_p, req_s, inv, inv_done);
    mb = step(mb, 1'b0, 0, req_p, req_s, inv, inv_done);
    @(posedge clk); #1;
    chk({name, "_a"}, 16'(act_a()), 16'(vis(ma)));
    chk({name, "_b"}, 16'(act_b()), 16'(vis(mb)));
    chk({name, "_onehot"}, 16'(($countones({a_gp, a_gs}) <= 1) && ($countones({b_gp, b_gs}) <= 1)), 16'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_p = '0; req_s = '0; inv = 1'b0; inv_done = '0;
    #2;
    chk("reset_a", 16'(act_a()), 16'd0);
    chk("reset_b", 16'(act_b()), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ma = mzero(); mb = mzero();
  endtask

  initial begin
    int k;

    //             rp      rs      iv    done     gp      gs      bz    ow     to    aid
    tbl[0]  = mk(4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[1]  = mk(4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[2]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[3]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[4]  = mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
    tbl[5]  = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[6]  = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[7]  = mk(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[8]  = mk(4'b0010, 4'b0000, 1'b1, 4'b1101, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b1);
    tbl[9]  = mk(4'b0010, 4'b0000, 1'b1, 4'b0101, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[10] = mk(4'b0010, 4'b0000, 1'b1, 4'b1101, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b1);
    tbl[11] = mk(4'b0010, 4'b0000, 1'b1, 4'b1101, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[12] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[13] = mk(4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
    tbl[14] = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[15] = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[16] = mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[17] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tbl[18] = mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    order = '{0, 1, 2, 3, 0};

    // Directed table against the snoop-first, MAX_HOLD=4 instance.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      req_p = tbl[i].rp; req_s = tbl[i].rs; inv = tbl[i].inv; inv_done = tbl[i].done;
      tick("tbl");
      chk($sformatf("tbl_row%0d", i), 16'(act_a()), 16'(tbl[i].exp));
    end

    // Simultaneous proc core0 / snoop core3: class priority decides.
    do_reset();
    req_p = 4'b0001; req_s = 4'b1000;
    tick("cls");
    chk("cls_snoop_first", 16'(a_gs), 16'b1000);
    chk("cls_proc_first",  16'(b_gp), 16'b0001);
    req_p = '0; req_s = '0;
    repeat (3) tick("cls_idle");

    // Watchdog: core2 held forever, core0 waiting behind it.
    do_reset();
    req_p = 4'b0100;
    tick("wd");
    req_p = 4'b0101;
    repeat (3) tick("wd_hold");
    chk("wd_still_granted", 16'(a_gp), 16'b0100);
    tick("wd_fire");
    chk("wd_pulse", 16'({a_to, a_gp}), 16'b10000);
    tick("wd_dead");
    chk("wd_pulse_end", 16'(a_to), 16'd0);
    tick("wd_next");
    chk("wd_next_owner", 16'({a_busy, a_gp}), 16'b10001);
    req_p = '0;
    repeat (3) tick("wd_idle");

    // Asynchronous reset in the middle of a grant.
    do_reset();
    req_p = 4'b0100;
    tick("mid");
    chk("mid_granted", 16'(a_gp), 16'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a", 16'(act_a()), 16'd0);
    chk("mid_rst_b", 16'(act_b()), 16'd0);
    req_p = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ma = mzero(); mb = mzero();
    req_p = 4'b1000;
    tick("post_rst");
    chk("post_rst_gnt", 16'(a_gp), 16'b1000);
    req_p = '0;
    repeat (3) tick("post_idle");

    // All four proc requesters, each releasing after two granted cycles.
    do_reset();
    k = 0;
    for (int c = 0; c < 60 && k < 5; c++) begin
      req_p = 4'b1111;
      if (ma.busy && ma.held == 2) req_p[ma.owner] = 1'b0;
      tick("rr");
      if (ma.busy && ma.held == 1) begin
        chk($sformatf("rr_owner%0d", k), 16'(a_own), 16'(order[k]));
        k++;
      end
    end
    chk("rr_grants_seen", 16'(k), 16'd5);
    req_p = '0;
    repeat (3) tick("rr_idle");

    // Random traffic against both models.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req_p = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_s = 4'($urandom_range(0, 15));
      inv      = 1'($urandom_range(0, 1));
      inv_done = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
